// File: rtl/poly_control.sv
// poly_control -- sequencer for the 16-bit polynomial datapath (X, S, H
// registers, three operand muxes, one add/multiply ALU).
//
// Mode 0 evaluates S = A*X^2 + B*X + C in Horner form:
//   S = ((A*X) + B)*X + C
// Mode 1 evaluates S = (X + A)*(X + B):
//   H = X + A ; S = X + B ; S = H*S
//
// Handshake: start is sampled only while idle (busy=0, done=0). The edge
// that sees start=1 in IDLE accepts the request and latches mode. busy is
// high from the next cycle through the last compute cycle. done is a
// one-cycle pulse, with busy low, in the cycle where S holds the result.
// A start seen in any other state, DONE included, is dropped. A start held
// high restarts after exactly one IDLE cycle.
//
// Ports:
//   clk          rising-edge clock shared with the datapath
//   rst_n        synchronous active-low reset
//   start        request a computation (IDLE only)
//   mode         0: A*X^2+B*X+C, 1: (X+A)*(X+B); latched with start
//   load_x       load X from the external operand
//   load_s       load S from the ALU result
//   load_h       load H from the ALU result
//   H            ALU op: 0 = add, 1 = multiply (low 16 bits)
//   sel_m0       operand mux: 01 = A, 10 = B, 11 = C (00 never driven)
//   sel_m1       ALU port a: 00 = m0, 01 = X, 10 = S, 11 = H
//   sel_m2       ALU port b: 00 = X, 01 = m0, 10 = S, 11 = H
//   busy         run in progress
//   done         result valid in S this cycle
//   dbg_state_o  current FSM state encoding, for observation only
//
// Every output is decoded from the state register alone (Moore), so there
// is no combinational path from start or mode to the datapath controls.

module poly_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  output logic       load_x,
  output logic       load_s,
  output logic       load_h,
  output logic       H,
  output logic [1:0] sel_m0,
  output logic [1:0] sel_m1,
  output logic [1:0] sel_m2,
  output logic       busy,
  output logic       done,
  output logic [3:0] dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LDX   = 4'd1,
    S_AX    = 4'd2,
    S_ADDB  = 4'd3,
    S_MULX  = 4'd4,
    S_ADDC  = 4'd5,
    S_HXA   = 4'd6,
    S_SXB   = 4'd7,
    S_MULHS = 4'd8,
    S_DONE  = 4'd9
  } state_e;

  // Mux encodings, named so the state table below reads like the datapath.
  localparam logic [1:0] M0_A = 2'b01;
  localparam logic [1:0] M0_B = 2'b10;
  localparam logic [1:0] M0_C = 2'b11;

  localparam logic [1:0] M1_M0 = 2'b00;
  localparam logic [1:0] M1_X  = 2'b01;
  localparam logic [1:0] M1_S  = 2'b10;
  localparam logic [1:0] M1_H  = 2'b11;

  localparam logic [1:0] M2_X  = 2'b00;
  localparam logic [1:0] M2_M0 = 2'b01;
  localparam logic [1:0] M2_S  = 2'b10;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  state_e state_q, state_d;
  logic   mode_q, mode_d;

  // State and latched mode register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic. mode is captured only on the accepting edge, so it
  // may change freely while a run is in flight.
  always_comb begin
    state_d = S_IDLE;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LDX;
          mode_d  = mode;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LDX:   state_d = mode_q ? S_HXA : S_AX;
      S_AX:    state_d = S_ADDB;
      S_ADDB:  state_d = S_MULX;
      S_MULX:  state_d = S_ADDC;
      S_ADDC:  state_d = S_DONE;
      S_HXA:   state_d = S_SXB;
      S_SXB:   state_d = S_MULHS;
      S_MULHS: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      // Unused encodings fall back to IDLE.
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode. The defaults are the IDLE outputs; sel_m0 defaults to A
  // so it can never select the forbidden self-feedback input.
  always_comb begin
    load_x = 1'b0;
    load_s = 1'b0;
    load_h = 1'b0;
    H      = OP_ADD;
    sel_m0 = M0_A;
    sel_m1 = M1_M0;
    sel_m2 = M2_X;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      S_IDLE: begin
      end
      S_LDX: begin
        load_x = 1'b1;
        busy   = 1'b1;
      end
      // S = A * X
      S_AX: begin
        load_s = 1'b1;
        H      = OP_MUL;
        sel_m0 = M0_A;
        sel_m1 = M1_M0;
        sel_m2 = M2_X;
        busy   = 1'b1;
      end
      // S = S + B
      S_ADDB: begin
        load_s = 1'b1;
        H      = OP_ADD;
        sel_m0 = M0_B;
        sel_m1 = M1_S;
        sel_m2 = M2_M0;
        busy   = 1'b1;
      end
      // S = S * X
      S_MULX: begin
        load_s = 1'b1;
        H      = OP_MUL;
        sel_m0 = M0_B;
        sel_m1 = M1_S;
        sel_m2 = M2_X;
        busy   = 1'b1;
      end
      // S = S + C
      S_ADDC: begin
        load_s = 1'b1;
        H      = OP_ADD;
        sel_m0 = M0_C;
        sel_m1 = M1_S;
        sel_m2 = M2_M0;
        busy   = 1'b1;
      end
      // H = X + A
      S_HXA: begin
        load_h = 1'b1;
        H      = OP_ADD;
        sel_m0 = M0_A;
        sel_m1 = M1_X;
        sel_m2 = M2_M0;
        busy   = 1'b1;
      end
      // S = X + B
      S_SXB: begin
        load_s = 1'b1;
        H      = OP_ADD;
        sel_m0 = M0_B;
        sel_m1 = M1_X;
        sel_m2 = M2_M0;
        busy   = 1'b1;
      end
      // S = H * S
      S_MULHS: begin
        load_s = 1'b1;
        H      = OP_MUL;
        sel_m0 = M0_A;
        sel_m1 = M1_H;
        sel_m2 = M2_S;
        busy   = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_poly_control.sv
// Bench for poly_control. Pairs the controller with a small behavioural
// model of the operative datapath so that final S values can be compared
// against hand-computed results.

module tb_poly_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        load_x, load_s, load_h, H;
  logic [1:0]  sel_m0, sel_m1, sel_m2;
  logic        busy, done;
  logic [3:0]  dbg_state;

  logic [15:0] a_op = 16'd0, b_op = 16'd0, c_op = 16'd0, x_op = 16'd0;
  logic [15:0] dp_x = 16'd0, dp_s = 16'd0, dp_h = 16'd0;
  logic [15:0] m0_v, alu_a, alu_b, alu_r;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic        accept_q = 1'b0;

  // Filled by run_op: control vector per cycle after the start edge.
  logic [9:0]  ctl [0:15];
  int          lat;
  int          bcnt;
  logic [15:0] h_at3;

  // clock / reset
  always #5 clk = ~clk;

  poly_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .load_x     (load_x),
    .load_s     (load_s),
    .load_h     (load_h),
    .H          (H),
    .sel_m0     (sel_m0),
    .sel_m1     (sel_m1),
    .sel_m2     (sel_m2),
    .busy       (busy),
    .done       (done),
    .dbg_state_o(dbg_state)
  );

  // Behavioural operative block.
  always_comb begin
    case (sel_m0)
      2'b01:   m0_v = a_op;
      2'b10:   m0_v = b_op;
      2'b11:   m0_v = c_op;
      default: m0_v = 16'hDEAD;
    endcase
    case (sel_m1)
      2'b00:   alu_a = m0_v;
      2'b01:   alu_a = dp_x;
      2'b10:   alu_a = dp_s;
      default: alu_a = dp_h;
    endcase
    case (sel_m2)
      2'b00:   alu_b = dp_x;
      2'b01:   alu_b = m0_v;
      2'b10:   alu_b = dp_s;
      default: alu_b = dp_h;
    endcase
    alu_r = H ? 16'(alu_a * alu_b) : 16'(alu_a + alu_b);
  end

  always @(posedge clk) begin
    if (load_x) dp_x <= x_op;
    if (load_s) dp_s <= alu_r;
    if (load_h) dp_h <= alu_r;
    if (done) done_cnt <= done_cnt + 1;
    // Idle is the only state with busy=0 and done=0, so this predicts
    // exactly the cycles in which LDX must be active.
    accept_q <= rst_n && start && !busy && !done;
  end

  // Invariants over every cycle of every run.
  always @(negedge clk) begin
    assert (sel_m0 != 2'b00)
      else $error("FAIL sel_m0_never_00: got %b required nonzero", sel_m0);
    assert (load_x === accept_q)
      else $error("FAIL load_x_only_in_ldx: got %b required %b", load_x, accept_q);
    assert (!(done && busy))
      else $error("FAIL done_with_busy: done=%b busy=%b required not both", done, busy);
  end

  // driver: one run from IDLE (caller is #1 after an edge, DUT idle).
  // Returns with the DUT back in IDLE. mode is flipped during the run to
  // show it is latched.
  task automatic run_op(input logic m, input logic [15:0] a, b, c, x);
    a_op = a; b_op = b; c_op = c; x_op = x;
    mode = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = ~m;
    lat = 0;
    bcnt = 0;
    h_at3 = 16'hFFFF;
    for (int i = 0; i < 16; i++) ctl[i] = '0;
    for (int i = 1; i <= 20; i++) begin
      if (i < 16) ctl[i] = {load_x, load_s, load_h, H, sel_m0, sel_m1, sel_m2};
      if (i == 3) h_at3 = dp_h;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({load_x, load_s, load_h, H} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_loads: got %b required 0000", {load_x, load_s, load_h, H});
    end
    checks++;
    if ({sel_m0, sel_m1, sel_m2} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_sels: got %b required 010000", {sel_m0, sel_m1, sel_m2});
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy_done: got %b required 00", {busy, done});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mode0();
    logic [9:0] e [1:6];
    e = '{10'b1000010000, 10'b0101010000, 10'b0100101001,
          10'b0101101000, 10'b0100111001, 10'b0000010000};
    run_op(1'b0, 16'd2, 16'd3, 16'd4, 16'd5);
    checks++;
    if (dp_s !== 16'd69) begin
      errors++;
      $display("FAIL mode0_result: got %0d required 69", dp_s);
    end
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL mode0_latency: got %0d required 6", lat);
    end
    checks++;
    if (bcnt !== 5) begin
      errors++;
      $display("FAIL mode0_busy_cycles: got %0d required 5", bcnt);
    end
    for (int i = 1; i <= 6; i++) begin
      checks++;
      if (ctl[i] !== e[i]) begin
        errors++;
        $display("FAIL mode0_ctl_cycle%0d: got %b required %b", i, ctl[i], e[i]);
      end
    end
  endtask

  task automatic test_mode1();
    logic [9:0] e [1:5];
    e = '{10'b1000010000, 10'b0010010101, 10'b0100100101,
          10'b0101011110, 10'b0000010000};
    run_op(1'b1, 16'd1, 16'd2, 16'd0, 16'd3);
    checks++;
    if (dp_s !== 16'd20) begin
      errors++;
      $display("FAIL mode1_result: got %0d required 20", dp_s);
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL mode1_latency: got %0d required 5", lat);
    end
    checks++;
    if (bcnt !== 4) begin
      errors++;
      $display("FAIL mode1_busy_cycles: got %0d required 4", bcnt);
    end
    checks++;
    if (h_at3 !== 16'd4) begin
      errors++;
      $display("FAIL mode1_h_after_hxa: got %0d required 4", h_at3);
    end
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (ctl[i] !== e[i]) begin
        errors++;
        $display("FAIL mode1_ctl_cycle%0d: got %b required %b", i, ctl[i], e[i]);
      end
    end
  endtask

  task automatic test_wrap();
    run_op(1'b0, 16'h0100, 16'h0000, 16'h0007, 16'h0100);
    checks++;
    if (dp_s !== 16'h0007) begin
      errors++;
      $display("FAIL wrap_result: got %h required 0007", dp_s);
    end
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL wrap_latency: got %0d required 6", lat);
    end
  endtask

  task automatic test_ignore_start();
    int d0;
    int l;
    int idle_busy;
    d0 = done_cnt;
    l = 0;
    idle_busy = 0;
    a_op = 16'd2; b_op = 16'd3; c_op = 16'd4; x_op = 16'd5;
    mode = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 2) start = 1'b1;
      if (i == 3) start = 1'b0;
      if (done) begin
        l = i;
        // start held through the DONE cycle only
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    repeat (8) begin
      if (busy) idle_busy++;
      @(posedge clk); #1;
    end
    checks++;
    if (l !== 6) begin
      errors++;
      $display("FAIL ignore_latency: got %0d required 6", l);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d required 1", done_cnt - d0);
    end
    checks++;
    if (dp_s !== 16'd69) begin
      errors++;
      $display("FAIL ignore_result: got %0d required 69", dp_s);
    end
    checks++;
    if (idle_busy !== 0) begin
      errors++;
      $display("FAIL ignore_no_rerun: got %0d busy cycles required 0", idle_busy);
    end
  endtask

  task automatic test_back_to_back();
    int l1;
    int l2;
    l1 = 0;
    l2 = 0;
    a_op = 16'd2; b_op = 16'd3; c_op = 16'd4; x_op = 16'd5;
    mode = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        l1 = i;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dp_s !== 16'd69) begin
      errors++;
      $display("FAIL b2b_first_result: got %0d required 69", dp_s);
    end
    @(posedge clk); #1;
    // IDLE gap cycle; new operands for the second run: ((1*4)+2)*4+3 = 27
    checks++;
    if ({busy, done, load_x} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_idle_gap: got %b required 000", {busy, done, load_x});
    end
    a_op = 16'd1; b_op = 16'd2; c_op = 16'd3; x_op = 16'd4;
    @(posedge clk); #1;
    checks++;
    if ({busy, load_x} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_restart_ldx: got %b required 11", {busy, load_x});
    end
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        l2 = i;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (l1 !== 6 || l2 !== 6) begin
      errors++;
      $display("FAIL b2b_latency: got %0d,%0d required 6,6", l1, l2);
    end
    checks++;
    if (dp_s !== 16'd27) begin
      errors++;
      $display("FAIL b2b_second_result: got %0d required 27", dp_s);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int d0;
    a_op = 16'd2; b_op = 16'd3; c_op = 16'd4; x_op = 16'd5;
    mode = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // now in the MULX cycle
    checks++;
    if ({load_x, load_s, load_h, H, sel_m0, sel_m1, sel_m2} !== 10'b0101101000) begin
      errors++;
      $display("FAIL midrst_in_mulx: got %b required 0101101000",
               {load_x, load_s, load_h, H, sel_m0, sel_m1, sel_m2});
    end
    d0 = done_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({load_x, load_s, load_h, H, sel_m0, sel_m1, sel_m2, busy, done} !== 12'b000001000000) begin
      errors++;
      $display("FAIL midrst_idle_outputs: got %b required 000001000000",
               {load_x, load_s, load_h, H, sel_m0, sel_m1, sel_m2, busy, done});
    end
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL midrst_no_done: got %0d pulses required 0", done_cnt - d0);
    end
    run_op(1'b0, 16'd2, 16'd3, 16'd4, 16'd5);
    checks++;
    if (dp_s !== 16'd69 || lat !== 6) begin
      errors++;
      $display("FAIL midrst_rerun: got %0d lat %0d required 69 lat 6", dp_s, lat);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_mode0();
    test_mode1();
    test_wrap();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

endmodule
